// File: rtl/button_debounce_pkg.sv
// Shared definitions for the pushbutton conditioning stages: FSM state encodings,
// the board default qualification time and the KEY idle level.
package button_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  // 10 ms of sampled stability at 50 MHz
  localparam int   DEFAULT_STABLE_CYCLES = 500000;
  localparam int   DEFAULT_CNT_W         = 20;
  // Board KEYs are active-low, so a released button reads high
  localparam logic KEY_IDLE_LEVEL        = 1'b1;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into the Clock domain.
// Both stages reset to RESET_VAL so no spurious edge is seen after Reset.
module sync_2ff
  import button_debounce_pkg::*;
#(
  parameter logic RESET_VAL = KEY_IDLE_LEVEL
) (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic sync_a;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_a <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      sync_a <= d;
      q      <= sync_a;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw pushbutton: synchronizer, then a counter-qualified two-state FSM
// producing a clean level plus one-cycle press/release strobes.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int   CNT_W         = DEFAULT_CNT_W,
  parameter logic IDLE_LEVEL    = KEY_IDLE_LEVEL
) (
  input  logic Clock,
  input  logic Reset,
  input  logic ButtonIn,
  output logic DebounceOut,
  output logic PressPulse,
  output logic ReleasePulse,
  output logic Busy
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || (longint'(1) << CNT_W) <= longint'(STABLE_CYCLES)) begin : g_bad_params
    $error("button_debounce: STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic         sync_b;
  state_t       state;
  logic [CNT_W-1:0] count;

  sync_2ff #(
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .Clock(Clock),
    .Reset(Reset),
    .d    (ButtonIn),
    .q    (sync_b)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_STABLE;
      count        <= '0;
      DebounceOut  <= IDLE_LEVEL;
      PressPulse   <= 1'b0;
      ReleasePulse <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      PressPulse   <= 1'b0;
      ReleasePulse <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (sync_b != DebounceOut) begin
            state <= ST_SETTLE;
            count <= CNT_W'(1);
            Busy  <= 1'b1;
          end else begin
            count <= '0;
          end
        end
        ST_SETTLE: begin
          // A level match always wins, even on the terminal count
          if (sync_b == DebounceOut) begin
            state <= ST_STABLE;
            count <= '0;
            Busy  <= 1'b0;
          end else if (count == TERMINAL) begin
            DebounceOut  <= sync_b;
            PressPulse   <= (sync_b != IDLE_LEVEL);
            ReleasePulse <= (sync_b == IDLE_LEVEL);
            state        <= ST_STABLE;
            count        <= '0;
            Busy         <= 1'b0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          count <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus random bouncing,
// compared every cycle against a history-based reference model.
module tb_button_debounce;

  localparam int   STABLE = 8;
  localparam int   CW     = 4;
  localparam logic IDLE   = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic dout, press, rel, busy;

  int checks = 0;
  int errors = 0;
  int press_cnt = 0;
  int rel_cnt = 0;

  // reference model state
  logic m_sa = IDLE, m_sb = IDLE, m_out = IDLE;
  logic e_press = 1'b0, e_rel = 1'b0, e_busy = 1'b0;
  logic hist[$];

  always #5 clk = ~clk;

  button_debounce #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (CW),
    .IDLE_LEVEL   (IDLE)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .ButtonIn    (btn),
    .DebounceOut (dout),
    .PressPulse  (press),
    .ReleasePulse(rel),
    .Busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Output flips once the last STABLE synchronized samples since the previous
  // change all disagree with the current output.
  task automatic model_edge(input logic b, input logic r);
    logic obs;
    logic all_diff;
    if (r) begin
      m_sa = IDLE; m_sb = IDLE; m_out = IDLE;
      e_press = 1'b0; e_rel = 1'b0; e_busy = 1'b0;
      hist.delete();
    end else begin
      obs  = m_sb;
      m_sb = m_sa;
      m_sa = b;
      hist.push_back(obs);
      if (hist.size() > STABLE) void'(hist.pop_front());
      all_diff = (hist.size() == STABLE);
      foreach (hist[i]) if (hist[i] == m_out) all_diff = 1'b0;
      e_press = 1'b0; e_rel = 1'b0;
      if (all_diff) begin
        m_out   = obs;
        e_press = (obs != IDLE);
        e_rel   = (obs == IDLE);
        e_busy  = 1'b0;
        hist.delete();
      end else begin
        e_busy = (obs != m_out);
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    chk("DebounceOut", 32'(dout), 32'(m_out));
    chk("PressPulse", 32'(press), 32'(e_press));
    chk("ReleasePulse", 32'(rel), 32'(e_rel));
    chk("Busy", 32'(busy), 32'(e_busy));
    if (press) press_cnt++;
    if (rel) rel_cnt++;
    $display("t=%0t rst=%0b btn=%0b out=%0b press=%0b rel=%0b busy=%0b", $time, r, b, dout, press, rel, busy);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int p0, r0, press_at, len;
    logic lvl;

    // 1: reset with the button pressed
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("reset_out", 32'(dout), 32'(IDLE));
    chk("reset_busy", 32'(busy), 32'd0);
    hold(1'b1, 12);
    chk("idle_after_reset", 32'(dout), 32'(IDLE));

    // 2: clean press, output changes on edge N+STABLE+1
    press_at = -1;
    p0 = press_cnt;
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 1'b0);
      if (press && press_at < 0) press_at = k;
    end
    chk("press_latency", 32'(press_at), 32'(STABLE + 2));
    chk("press_count", 32'(press_cnt - p0), 32'd1);
    hold(1'b1, 14);
    chk("released", 32'(dout), 32'(IDLE));

    // 3: bounce restarts qualification
    p0 = press_cnt;
    hold(1'b0, 5);
    hold(1'b1, 1);
    hold(1'b0, 9);
    chk("bounce_no_early", 32'(press_cnt - p0), 32'd0);
    hold(1'b0, 4);
    chk("bounce_press", 32'(press_cnt - p0), 32'd1);

    // 4: glitch landing on the terminal count
    r0 = rel_cnt;
    hold(1'b1, 7);
    hold(1'b0, 1);
    hold(1'b1, 2);
    chk("terminal_no_release", 32'(rel_cnt - r0), 32'd0);
    chk("terminal_out", 32'(dout), 32'd0);
    hold(1'b1, 14);
    chk("terminal_late_release", 32'(rel_cnt - r0), 32'd1);

    // 5: reset mid-SETTLE, then pressed through reset release
    p0 = press_cnt;
    hold(1'b0, 7);
    step(1'b0, 1'b1);
    chk("midreset_out", 32'(dout), 32'(IDLE));
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_nopress", 32'(press_cnt - p0), 32'd0);
    hold(1'b0, 12);
    chk("post_reset_press", 32'(press_cnt - p0), 32'd1);
    hold(1'b1, 14);

    // 6: chatter faster than qualification time
    p0 = press_cnt;
    r0 = rel_cnt;
    for (int i = 0; i < 200; i++) begin
      step(((i / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
      chk("chatter_out", 32'(dout), 32'(IDLE));
    end
    chk("chatter_pulses", 32'(press_cnt - p0 + rel_cnt - r0), 32'd0);

    // 7: random bouncing with occasional reset
    for (int s = 0; s < 80; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      if ($urandom_range(0, 29) == 0) step(lvl, 1'b1);
      hold(lvl, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
